jtag_master_ctrl: RTL and testbench
===================================

Name: jtag_master_ctrl

Overview:
- Synthesizable, parametrised JTAG TAP master. Successor to the behavioural stimulus driver for the JTAG port.
- Accepts queued commands from an on-chip or FPGA-side controller: TAP reset, IR shift, DR shift, idle clocks.
- Generates TCK/TMS/TDI at a programmable divided rate and returns captured TDO bits as a response word.
- Sits between the host command interface and the chip-level JTAG pins.

Parameters:
- DATA_W, 64, maximum shift length in bits; width of cmd_data and rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W >= DATA_W.
- DIV_W, 8, width of the TCK half-period divider input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tck_div  in  DIV_W  TCK half-period in clk cycles; 0 is treated as 1; sampled at command accept
- cmd_valid  in  1  command present
- cmd_ready  out  1  master idle and able to accept a command
- cmd_type  in  2  0=TAP reset, 1=IR shift, 2=DR shift, 3=idle clocks
- cmd_len  in  LEN_W  number of bits (types 1/2) or TCK cycles (types 0/3), minus 1
- cmd_data  in  DATA_W  TDI bits, LSB shifted first
- rsp_valid  out  1  one-cycle pulse, captured data valid (types 1/2 only)
- rsp_data  out  DATA_W  captured TDO bits; bit i = i-th bit shifted out
- busy  out  1  high from command accept until the return to Run-Test/Idle completes
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to device
- tdo  in  1  JTAG data from device; synchronised through 2 flops internally

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0 until first clk after reset release then 1, rsp_valid=0, rsp_data=0, busy=0. TAP position is unknown after reset.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready. cmd_ready drops the following cycle and stays low until the command sequence completes. cmd_data, cmd_len, cmd_type and tck_div are registered at accept.
- TCK generation:
  - A divider counter counts tck_div clk cycles per phase, so one TCK period = 2*tck_div clk cycles.
  - tms and tdi update only on the clk cycle that drives tck 1->0.
  - TDO (after synchroniser) is sampled on the cycle tck goes 0->1, i.e. the device samples on the rising edge.
  - tck idles at 0 whenever busy=0.
- FSM states: IDLE, RST, PRE, SHIFT, POST, RTI, RESP.
  - RST (type 0): cmd_len+1 TCK cycles with tms=1, minimum 5 enforced (cmd_len<4 still yields 5). Then one TCK with tms=0, ending in Run-Test/Idle.
  - PRE: DR path drives tms sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR). IR path drives 1,1,0,0.
  - SHIFT: cmd_len+1 TCK cycles. tdi = cmd_data[i]. tms=0 except on the last bit, where tms=1 (Exit1).
  - POST: tms 1 (Update), then 0 (Run-Test/Idle).
  - RTI (type 3): cmd_len+1 TCK cycles with tms=0.
  - RESP: one clk with rsp_valid=1. rsp_data bits above cmd_len are 0. rsp_data holds its value until the next response.
  - Return to IDLE: cmd_ready=1 on the following cycle.
- Every command except type 0 starts and ends in Run-Test/Idle. The host must issue type 0 first after power-up; the master does not enforce this.
- cmd_len+1 > DATA_W: length is clamped to DATA_W.
- tdo sampling: the bit captured on the rising edge of shift bit i is stored at rsp_data[i].
- Back-to-back commands: the next accept is possible on the cycle after cmd_ready rises. No overlapping TCK.
- reset_n asserted mid-command: all outputs return to reset values immediately (asynchronously). The in-flight command is discarded with no rsp_valid.

Test Plan:
- Reset mid-SHIFT of DR len 31 -> tck=0, tms=1, busy=0 asynchronously; no rsp_valid; after release cmd_ready=1.
- Type 0, cmd_len=0, tck_div=2 -> 5 TCK with tms=1 then 1 with tms=0; each TCK period 4 clk; cmd_ready low throughout.
- IR shift len=6 (7 bits), cmd_data=7'h55, TAP model with IR capture 7'b0000001 -> tms sequence 1,1,0,0,(0x6),1,1,0; tdi LSB-first 1,0,1,0,1,0,1; rsp_data=7'h01.
- DR shift len=63, data=64'hDEADBEEF_01234567, TAP model loops TDI to TDO through a 1-bit bypass -> rsp_data = data<<1 with bit0 = bypass capture 0.
- cmd_len=127 with DATA_W=64 -> exactly 64 shift TCKs; rsp_valid one pulse.
- Back-to-back DR then idle(len=9) with cmd_valid held high -> second accept on cycle after cmd_ready rises; 10 TCK with tms=0; no rsp_valid for idle.

Source files
------------

// File: rtl/jtag_master_ctrl.sv
// JTAG TAP master: runs queued TAP reset / IR / DR / idle commands
// at a divided TCK rate and returns the captured TDO bits.
module jtag_master_ctrl #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 6,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  tck_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int CW = LEN_W + 2;
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, RST, PRE, SHIFT, POST, RTI, RESP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DIV_W-1:0]  div_cnt, div_q;
  logic [LEN_W-1:0]  len_q;
  logic              ir_q;
  logic [DATA_W-1:0] data_q, cap_q;
  logic              sync1, tdo_s;

  // Index of the final TCK step of each sequencing state
  function automatic logic [CW-1:0] last_of(
    input state_t           s,
    input logic [LEN_W-1:0] len,
    input logic             ir
  );
    logic [CW-1:0] l, r;
    l = CW'(len);
    r = '0;
    case (s)
      RST:     r = ((l < CW'(4)) ? CW'(4) : l) + CW'(1);
      PRE:     r = ir ? CW'(3) : CW'(2);
      SHIFT:   r = (l > CW'(DATA_W-1)) ? CW'(DATA_W-1) : l;
      POST:    r = CW'(1);
      RTI:     r = l;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic tms_of(
    input state_t        s,
    input logic [CW-1:0] c,
    input logic [CW-1:0] lst,
    input logic          ir
  );
    logic t;
    case (s)
      RST:     t = (c != lst);
      PRE:     t = ir ? (c < CW'(2)) : (c == '0);
      SHIFT:   t = (c == lst);
      POST:    t = (c == '0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic              accept, active, div_hit, rise, fall;
  logic [CW-1:0]     last, n_last;
  logic [LEN_W-1:0]  n_len;
  logic              n_ir, n_act;
  logic [DATA_W-1:0] n_data;

  assign accept  = cmd_valid && cmd_ready;
  assign active  = state inside {RST, PRE, SHIFT, POST, RTI};
  assign div_hit = active && (div_cnt == div_q - DIV_W'(1));
  assign rise    = div_hit && !tck;
  assign fall    = div_hit && tck;
  assign last    = last_of(state, len_q, ir_q);

  assign n_len  = accept ? cmd_len : len_q;
  assign n_ir   = accept ? (cmd_type == 2'd1) : ir_q;
  assign n_data = accept ? cmd_data : data_q;
  assign n_last = last_of(state_d, n_len, n_ir);
  assign n_act  = state_d inside {RST, PRE, SHIFT, POST, RTI};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          unique case (cmd_type)
            2'd0:    state_d = RST;
            2'd3:    state_d = RTI;
            default: state_d = PRE;
          endcase
        end
      end
      RESP: state_d = IDLE;
      default: begin
        if (fall) begin
          if (cnt == last) begin
            cnt_d = '0;
            case (state)
              PRE:     state_d = SHIFT;
              SHIFT:   state_d = POST;
              POST:    state_d = RESP;
              default: state_d = IDLE;
            endcase
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  // tdo reaches tdo_s two clk after it changes, so shifts need tck_div >= 3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      div_cnt   <= '0;
      div_q     <= DIV_W'(1);
      len_q     <= '0;
      ir_q      <= 1'b0;
      data_q    <= '0;
      cap_q     <= '0;
      sync1     <= 1'b0;
      tdo_s     <= 1'b0;
    end else begin
      sync1     <= tdo;
      tdo_s     <= sync1;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE) && (state_d != RESP);
      rsp_valid <= (state_d == RESP);
      if (state_d == RESP)
        rsp_data <= cap_q;
      if (accept) begin
        div_q   <= (tck_div == '0) ? DIV_W'(1) : tck_div;
        len_q   <= cmd_len;
        ir_q    <= (cmd_type == 2'd1);
        data_q  <= cmd_data;
        cap_q   <= '0;
        div_cnt <= '0;
        tck     <= 1'b0;
      end else if (active) begin
        div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
        if (div_hit)
          tck <= ~tck;
        if (rise && state == SHIFT)
          cap_q[cnt[IW-1:0]] <= tdo_s;
      end else begin
        div_cnt <= '0;
        tck     <= 1'b0;
      end
      if ((accept || fall) && n_act) begin
        tms <= tms_of(state_d, cnt_d, n_last, n_ir);
        tdi <= (state_d == SHIFT) ? n_data[cnt_d[IW-1:0]] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_master_ctrl.sv
// Bench for jtag_master_ctrl: TAP device model on the pins and a
// response scoreboard fed at command issue.
module tb_jtag_master_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tck_div;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        busy;
  logic        tck, tms, tdi;
  logic        tdo_m = 1'b0;

  jtag_master_ctrl #(.DATA_W(64), .LEN_W(7), .DIV_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .tck_div(tck_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo_m)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TAP device model: 7-bit IR capturing 0000001, 1-bit bypass DR
  typedef enum int {
    TLR, RTI_S, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_t;

  tap_t       ts = E1DR;
  logic [6:0] ir_sr = '0;
  logic [6:0] ir = '0;
  logic       byp = 1'b0;

  always @(posedge tck) begin
    case (ts)
      CIR:  ir_sr = 7'b0000001;
      SHIR: ir_sr = {tdi, ir_sr[6:1]};
      CDR:  byp = 1'b0;
      SHDR: byp = tdi;
      UIR:  ir = ir_sr;
      default: ;
    endcase
    case (ts)
      TLR:   ts = tms ? TLR  : RTI_S;
      RTI_S: ts = tms ? SDR  : RTI_S;
      SDR:   ts = tms ? SIR  : CDR;
      CDR:   ts = tms ? E1DR : SHDR;
      SHDR:  ts = tms ? E1DR : SHDR;
      E1DR:  ts = tms ? UDR  : PDR;
      PDR:   ts = tms ? E2DR : PDR;
      E2DR:  ts = tms ? UDR  : SHDR;
      UDR:   ts = tms ? SDR  : RTI_S;
      SIR:   ts = tms ? TLR  : CIR;
      CIR:   ts = tms ? E1IR : SHIR;
      SHIR:  ts = tms ? E1IR : SHIR;
      E1IR:  ts = tms ? UIR  : PIR;
      PIR:   ts = tms ? E2IR : PIR;
      E2IR:  ts = tms ? UIR  : SHIR;
      default: ts = tms ? SDR : RTI_S;
    endcase
  end

  always @(negedge tck)
    tdo_m <= (ts == SHIR) ? ir_sr[0] : (ts == SHDR) ? byp : 1'b0;

  logic [127:0] tms_v, tdi_v;
  int           n_tck;
  time          rise_t[$];

  always @(posedge tck) begin
    tms_v = {tms_v[126:0], tms};
    tdi_v = {tdi_v[126:0], tdi};
    n_tck++;
    rise_t.push_back($time);
  end

  task automatic clr_log();
    tms_v = '0;
    tdi_v = '0;
    n_tck = 0;
    rise_t.delete();
  endtask

  logic [63:0] exp_q[$];
  int   n_rsp = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   acc_cyc = -2;
  logic prev_rdy = 1'b0;
  logic rdy_busy = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [63:0] e;
    if (cmd_ready && busy) rdy_busy = 1'b1;
    if (cmd_ready && !prev_rdy) rise_cyc = cyc;
    if (cmd_ready && cmd_valid) acc_cyc = cyc;
    prev_rdy = cmd_ready;
    if (rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e);
      end
    end
  end

  function automatic logic [63:0] exp_dr(input logic [63:0] d,
                                         input int n);
    logic [63:0] m;
    m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return (d << 1) & m;
  endfunction

  function automatic logic [63:0] exp_ir(input logic [63:0] d,
                                         input int n);
    logic [63:0] r;
    logic [6:0]  cap;
    r = '0;
    cap = 7'b0000001;
    for (int i = 0; i < n; i++)
      r[i] = (i < 7) ? cap[i] : d[i-7];
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [6:0] len,
                         input logic [63:0] d, input logic [7:0] div);
    wait_ready("pre_cmd");
    clr_log();
    cmd_type  = t;
    cmd_len   = len;
    cmd_data  = d;
    tck_div   = div;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready("cmd_done");
  endtask

  initial begin
    time         mn, mx, df;
    logic [63:0] d;
    int          n0, dr_tck, k;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    tck_div   = 8'd2;
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", cmd_ready, 1);

    rdy_busy = 1'b0;
    run_cmd(2'd0, 7'd0, 64'd0, 8'd2);
    chk("tlr_tck_count", 64'(n_tck), 64'd6);
    chk("tlr_tms_seq", tms_v[5:0], 6'b111110);
    mn = 64'hFFFF;
    mx = 0;
    for (int i = 1; i < rise_t.size(); i++) begin
      df = rise_t[i] - rise_t[i-1];
      if (df < mn) mn = df;
      if (df > mx) mx = df;
    end
    chk("tlr_period_min", mn, 64'd40);
    chk("tlr_period_max", mx, 64'd40);
    chk("tlr_ready_while_busy", rdy_busy, 0);
    chk("tlr_tap_rti", ts == RTI_S, 1);

    exp_q.push_back(exp_ir(64'h55, 7));
    run_cmd(2'd1, 7'd6, 64'h55, 8'd4);
    chk("ir_tck_count", 64'(n_tck), 64'd13);
    chk("ir_tms_seq", tms_v[12:0], 13'b1100000000110);
    chk("ir_tdi_seq", tdi_v[8:2], 7'b1010101);
    chk("ir_reg", ir, 7'h55);
    chk("ir_tap_rti", ts == RTI_S, 1);

    d = 64'hDEADBEEF_01234567;
    exp_q.push_back(exp_dr(d, 64));
    run_cmd(2'd2, 7'd63, d, 8'd4);
    chk("dr64_tck_count", 64'(n_tck), 64'd69);

    d = {$urandom, $urandom};
    n0 = n_rsp;
    exp_q.push_back(exp_dr(d, 64));
    run_cmd(2'd2, 7'd127, d, 8'd3);
    chk("clamp_tck_count", 64'(n_tck), 64'd69);
    chk("clamp_rsp_pulses", 64'(n_rsp - n0), 64'd1);

    wait_ready("b2b_pre");
    clr_log();
    n0 = n_rsp;
    exp_q.push_back(exp_dr(64'hA5, 8));
    cmd_type  = 2'd2;
    cmd_len   = 7'd7;
    cmd_data  = 64'hA5;
    tck_div   = 8'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_type = 2'd3;
    cmd_len  = 7'd9;
    cmd_data = '0;
    wait_ready("b2b_dr");
    dr_tck = n_tck;
    clr_log();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_ready("b2b_idle");
    chk("b2b_dr_tck_count", 64'(dr_tck), 64'd13);
    chk("b2b_accept_cycle", 64'(acc_cyc), 64'(rise_cyc));
    chk("idle_tck_count", 64'(n_tck), 64'd10);
    chk("idle_tms_zero", tms_v[9:0], 10'd0);
    chk("b2b_rsp_pulses", 64'(n_rsp - n0), 64'd1);

    wait_ready("mid_pre");
    clr_log();
    n0 = n_rsp;
    cmd_type  = 2'd2;
    cmd_len   = 7'd31;
    cmd_data  = {$urandom, $urandom};
    tck_div   = 8'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (n_tck < 13 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_shift", ts == SHDR, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_tck", tck, 0);
    chk("mid_rst_tms", tms, 1);
    chk("mid_rst_tdi", tdi, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ready_after", cmd_ready, 1);
    chk("mid_rsp_data", rsp_data, 0);
    repeat (4) @(negedge clk);
    chk("mid_no_rsp", 64'(n_rsp - n0), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
